bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 38 +++
 rtl/bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus bundle for bus_arbiter: four packed client channels plus one RAM channel.
//   master modport : arbiter view (takes client requests and RAM responses,
//                    drives client completions and RAM requests)
//   slave  modport : environment view (clients + RAM), opposite directions
// Client n occupies slice n of every packed client vector.
interface bus_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned NUM_CLIENTS = 4;

   // client side
   logic [NUM_CLIENTS-1:0]            cl_rq;
   logic [NUM_CLIENTS-1:0]            cl_wr_ni;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW;
   logic [NUM_CLIENTS-1:0]            cl_ack;
   logic                              cl_err;
   logic [DATA_WIDTH-1:0]             cl_dataR;

   // RAM side
   logic                              mem_rq;
   logic                              mem_wr_ni;
   logic [ADDR_WIDTH-1:0]             mem_addr;
   logic [DATA_WIDTH-1:0]             mem_dataW;
   logic                              mem_ack;
   logic [DATA_WIDTH-1:0]             mem_dataR;

   modport master (
      input  cl_rq, cl_wr_ni, cl_addr, cl_dataW, mem_ack, mem_dataR,
      output cl_ack, cl_err, cl_dataR, mem_rq, mem_wr_ni, mem_addr, mem_dataW
   );

   modport slave (
      output cl_rq, cl_wr_ni, cl_addr, cl_dataW, mem_ack, mem_dataR,
      input  cl_ack, cl_err, cl_dataR, mem_rq, mem_wr_ni, mem_addr, mem_dataW
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one single-port RAM among 4 clients.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP: the winning client's
// op/addr/data are latched in IDLE, mem_rq pulses for one cycle in ISSUE, WAIT
// holds until mem_ack, and RESP carries a one-cycle cl_ack pulse to the winner.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : bus_arbiter_if.master (client request/ack bundle + RAM channel)
// Build option: define BUS_ARBITER_TIMEOUT_EN to give up on a RAM access after
// TIMEOUT_CYCLES cycles in WAIT and complete it with cl_err=1, cl_dataR=0.
// Without it WAIT lasts until mem_ack and cl_err is tied to 0.
module bus_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input logic            clk,
   input logic            rst,
   bus_arbiter_if.master  bus
);

   localparam int unsigned NUM_CLIENTS = 4;
   localparam int unsigned IDX_W       = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]             state_q,      state_d;
   logic [IDX_W-1:0]       grant_q,      grant_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic                   mem_rq_q,     mem_rq_d;
   logic                   mem_wr_ni_q,  mem_wr_ni_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
   logic [DATA_WIDTH-1:0]  mem_data_w_q, mem_data_w_d;
   logic [NUM_CLIENTS-1:0] cl_ack_q,     cl_ack_d;
   logic [DATA_WIDTH-1:0]  cl_data_r_q,  cl_data_r_d;

   logic                   rr_any_c;
   logic [IDX_W-1:0]       rr_pick_c;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0]       tmo_cnt_q,    tmo_cnt_d;
   logic                   cl_err_q,     cl_err_d;
`else
   // TIMEOUT_CYCLES only shapes the timeout build; fold it into a sink here
   logic                   unused_c;
   assign unused_c = ^32'(TIMEOUT_CYCLES);
`endif

   // Round-robin pick: scan from last_grant+1 upward with 2-bit wrap; the
   // loop runs farthest-first so the nearest requester overwrites the pick.
   always_comb begin
      rr_any_c  = |bus.cl_rq;
      rr_pick_c = last_grant_q;
      for (int i = int'(NUM_CLIENTS); i >= 1; i--) begin
         if (bus.cl_rq[last_grant_q + IDX_W'(i)]) begin
            rr_pick_c = last_grant_q + IDX_W'(i);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      mem_rq_d     = 1'b0;
      mem_wr_ni_d  = mem_wr_ni_q;
      mem_addr_d   = mem_addr_q;
      mem_data_w_d = mem_data_w_q;
      cl_ack_d     = '0;
      cl_data_r_d  = cl_data_r_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      cl_err_d     = cl_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (rr_any_c) begin
               state_d      = S_ISSUE;
               grant_d      = rr_pick_c;
               mem_rq_d     = 1'b1;
               mem_wr_ni_d  = bus.cl_wr_ni[rr_pick_c];
               mem_addr_d   = bus.cl_addr[32'(rr_pick_c) * ADDR_WIDTH +: ADDR_WIDTH];
               mem_data_w_d = bus.cl_dataW[32'(rr_pick_c) * DATA_WIDTH +: DATA_WIDTH];
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end

         S_WAIT: begin
            if (bus.mem_ack) begin
               state_d  = S_RESP;
               cl_ack_d = NUM_CLIENTS'(1) << grant_q;
               // mem_wr_ni_q = 1 means read; writes leave cl_dataR untouched
               if (mem_wr_ni_q) begin
                  cl_data_r_d = bus.mem_dataR;
               end
`ifdef BUS_ARBITER_TIMEOUT_EN
               cl_err_d = 1'b0;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               // counter holds the number of WAIT edges already spent
               state_d     = S_RESP;
               cl_ack_d    = NUM_CLIENTS'(1) << grant_q;
               cl_err_d    = 1'b1;
               cl_data_r_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
            end
         end

         S_RESP: begin
            state_d      = S_IDLE;
            last_grant_d = grant_q;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
         mem_rq_q     <= 1'b0;
         mem_wr_ni_q  <= 1'b1;
         mem_addr_q   <= '0;
         mem_data_w_q <= '0;
         cl_ack_q     <= '0;
         cl_data_r_q  <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         cl_err_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         mem_rq_q     <= mem_rq_d;
         mem_wr_ni_q  <= mem_wr_ni_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_w_q <= mem_data_w_d;
         cl_ack_q     <= cl_ack_d;
         cl_data_r_q  <= cl_data_r_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         cl_err_q     <= cl_err_d;
`endif
      end
   end

   assign bus.mem_rq    = mem_rq_q;
   assign bus.mem_wr_ni = mem_wr_ni_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_dataW = mem_data_w_q;
   assign bus.cl_ack    = cl_ack_q;
   assign bus.cl_dataR  = cl_data_r_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
   assign bus.cl_err    = cl_err_q;
`else
   assign bus.cl_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed and randomized client traffic against a
// behavioural RAM, checked with a transaction-level round-robin model.
module tb_bus_arbiter;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst;
   bit   ram_mute = 1'b0;

   bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) arb_bus ();

   bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (arb_bus)
   );

   always #5 clk = ~clk;

   // RAM: ack is a registered copy of mem_rq, read data valid with ack
   logic [DW-1:0] ram [16];
   always @(posedge clk) begin
      arb_bus.mem_ack <= arb_bus.mem_rq & ~ram_mute;
      if (arb_bus.mem_rq === 1'b1) begin
         if (arb_bus.mem_wr_ni) arb_bus.mem_dataR <= ram[arb_bus.mem_addr];
         else                   ram[arb_bus.mem_addr] <= arb_bus.mem_dataW;
      end
   end

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   // reference model state
   logic          op_rd   [4];
   logic [AW-1:0] op_addr [4];
   logic [DW-1:0] op_data [4];
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] ref_dataR;
   int            ref_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int c, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_rd[c] = rd; op_addr[c] = a; op_data[c] = d;
   endtask

   task automatic random_ops();
      for (int c = 0; c < 4; c++)
         set_op(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
   endtask

   // Present the clients in mask with op_* and follow every cycle until all are served.
   task automatic run_batch(input logic [3:0] mask, input bit drop_early);
      int            order [$];
      logic [DW-1:0] exp_rd [$];
      logic [3:0]    pend;
      int            cur, n, j, ph;
      logic [3:0]    exp_ack;

      pend = mask;
      cur  = ref_last;
      while (pend != 4'b0) begin
         int g;
         g = -1;
         for (int s = 1; s <= 4 && g < 0; s++)
            if (pend[(cur + s) % 4]) g = (cur + s) % 4;
         order.push_back(g);
         pend[g] = 1'b0;
         cur     = g;
         if (op_rd[g]) ref_dataR = ref_mem[op_addr[g]];
         else          ref_mem[op_addr[g]] = op_data[g];
         exp_rd.push_back(ref_dataR);
      end
      ref_last = cur;
      n = order.size();

      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         arb_bus.cl_wr_ni[c]          = op_rd[c];
         arb_bus.cl_addr[c*AW +: AW]  = op_addr[c];
         arb_bus.cl_dataW[c*DW +: DW] = op_data[c];
      end
      arb_bus.cl_rq = mask;

      for (int c = 0; c < 4*n + 2; c++) begin
         @(posedge clk); #1;
         j  = c / 4;
         ph = c % 4;
         exp_ack = (ph == 2 && j < n) ? 4'(1 << order[j]) : 4'b0;
         check("mem_rq", 32'(arb_bus.mem_rq), 32'(ph == 0 && j < n));
         check("cl_ack", 32'(arb_bus.cl_ack), 32'(exp_ack));
         if (j < n && ph < 2) begin
            check("mem_addr",  32'(arb_bus.mem_addr),  32'(op_addr[order[j]]));
            check("mem_wr_ni", 32'(arb_bus.mem_wr_ni), 32'(op_rd[order[j]]));
            check("mem_dataW", 32'(arb_bus.mem_dataW), 32'(op_data[order[j]]));
         end
         if (j < n && ph == 1 && drop_early) arb_bus.cl_rq[order[j]] = 1'b0;
         if (j < n && ph == 2) begin
            check("cl_dataR", 32'(arb_bus.cl_dataR), 32'(exp_rd[j]));
            check("cl_err",   32'(arb_bus.cl_err),   32'(0));
            arb_bus.cl_rq[order[j]] = 1'b0;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_rq"},    32'(arb_bus.mem_rq),    32'(0));
      check({tag, "_cl_ack"},    32'(arb_bus.cl_ack),    32'(0));
      check({tag, "_cl_err"},    32'(arb_bus.cl_err),    32'(0));
      check({tag, "_cl_dataR"},  32'(arb_bus.cl_dataR),  32'(0));
      check({tag, "_mem_addr"},  32'(arb_bus.mem_addr),  32'(0));
      check({tag, "_mem_dataW"}, 32'(arb_bus.mem_dataW), 32'(0));
      check({tag, "_mem_wr_ni"}, 32'(arb_bus.mem_wr_ni), 32'(1));
   endtask

   initial begin
      rst              = 1'b1;
      arb_bus.cl_rq    = '0;
      arb_bus.cl_wr_ni = '1;
      arb_bus.cl_addr  = '0;
      arb_bus.cl_dataW = '0;
      ref_last         = 3;
      ref_dataR        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // all four contend straight out of reset: served 0,1,2,3 four cycles apart
      for (int c = 0; c < 4; c++) set_op(c, 1'b0, AW'(c), DW'($urandom));
      run_batch(4'b1111, 1'b0);

      // fill the whole RAM so later reads have known contents
      for (int a = 0; a < 16; a++) begin
         set_op(a % 4, 1'b0, AW'(a), DW'($urandom));
         run_batch(4'(1 << (a % 4)), 1'b0);
      end

      // single read of a preloaded word
      set_op(2, 1'b0, 4'h3, 8'hA5);
      run_batch(4'b0100, 1'b0);
      set_op(1, 1'b1, 4'h3, 8'h00);
      run_batch(4'b0010, 1'b0);
      check("single_read_data", 32'(arb_bus.cl_dataR), 32'h0000_00A5);

      // write then read back by the same client
      set_op(0, 1'b0, 4'h9, 8'h5C);
      run_batch(4'b0001, 1'b0);
      set_op(0, 1'b1, 4'h9, 8'h00);
      run_batch(4'b0001, 1'b0);
      check("write_read_data", 32'(arb_bus.cl_dataR), 32'h0000_005C);

      // fairness wrap: after client 3 is served, 0 beats 3
      set_op(3, 1'b1, 4'h1, 8'h00);
      run_batch(4'b1000, 1'b0);
      set_op(0, 1'b1, 4'h2, 8'h00);
      set_op(3, 1'b1, 4'h4, 8'h00);
      run_batch(4'b1001, 1'b0);

      // reset while WAIT is pending: transaction abandoned without ack
      set_op(2, 1'b1, 4'h7, 8'h00);
      @(negedge clk);
      arb_bus.cl_wr_ni[2]       = 1'b1;
      arb_bus.cl_addr[2*AW +: AW] = 4'h7;
      arb_bus.cl_rq             = 4'b0100;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst           = 1'b0;
      arb_bus.cl_rq = '0;
      ref_last      = 3;
      ref_dataR     = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("rst_quiet_ack", 32'(arb_bus.cl_ack), 32'(0));
         check("rst_quiet_rq",  32'(arb_bus.mem_rq), 32'(0));
      end
      // last_grant back at 3: client 0 wins over client 2
      set_op(0, 1'b1, 4'h9, 8'h00);
      set_op(2, 1'b1, 4'h3, 8'h00);
      run_batch(4'b0101, 1'b0);

`ifdef BUS_ARBITER_TIMEOUT_EN
      // RAM silent: completion with error 15 cycles after entering WAIT
      ram_mute = 1'b1;
      @(negedge clk);
      arb_bus.cl_wr_ni[1]         = 1'b1;
      arb_bus.cl_addr[1*AW +: AW] = 4'h5;
      arb_bus.cl_rq               = 4'b0010;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         check("tmo_mem_rq", 32'(arb_bus.mem_rq), 32'(c == 0));
         check("tmo_cl_ack", 32'(arb_bus.cl_ack), (c == 16) ? 32'h2 : 32'h0);
         if (c == 16) begin
            check("tmo_cl_err",   32'(arb_bus.cl_err),   32'(1));
            check("tmo_cl_dataR", 32'(arb_bus.cl_dataR), 32'(0));
            arb_bus.cl_rq = '0;
         end
      end
      ram_mute  = 1'b0;
      ref_last  = 1;
      ref_dataR = '0;
`endif

      // randomized traffic, sometimes dropping the request right after grant
      for (int t = 0; t < 30; t++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         random_ops();
         run_batch(m, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
